audio_play_fifo: RTL and testbench
==================================

# audio_play_fifo

Memory-mapped stereo playback buffer between the MIPS data bus and the audio codec output path. The processor writes left/right 16-bit samples through MMIO. The block packs each pair into a 16-entry FIFO and emits one pair per frame request to the audio converter's `audio_outL`/`audio_outR` inputs. It also exposes a status word so software can poll for space instead of spinning on the LR clock.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries, power of two, ≥ 2.
- `OUTRDATA`, 32'h40000008: right-sample write address; the write pushes the pair.
- `OUTLDATA`, 32'h4000000C: left-sample holding register address.
- `STATUS`, 32'h40000010: status read address.
- `CTRL`, 32'h40000014: control write address.

Ports:
- `CLK` in 1: processor clock; all state is updated on its rising edge.
- `AUD_DACLRCK` in 1: reset, asynchronous, active-low.
- `iMemWrite` in 1: bus write strobe, one cycle per store.
- `iMemRead` in 1: bus read strobe.
- `iwMemAddress` in 32: byte address.
- `iwMemWriteData` in 32: store data; the sample is bits [15:0].
- `oMemReadData` out 32: combinational read data. It is 0 unless `iMemRead` is high and the address matches.
- `iSampleReq` in 1: single-cycle pulse per stereo frame, already synchronous to `CLK`.
- `oAudioL` out 16: current left sample to the converter.
- `oAudioR` out 16: current right sample to the converter.
- `oFull` out 1: FIFO holds `DEPTH` entries.
- `oEmpty` out 1: FIFO holds 0 entries.

## Operation
- **Reset (`AUD_DACLRCK` = 0):**
  - Pointers and level are 0.
  - `oEmpty`=1, `oFull`=0.
  - `oAudioL`=`oAudioR`=0.
  - Holding register `holdL`=0.
  - Sticky flags `underrun` and `overflow` are 0.
- **Write to `OUTLDATA`:** `holdL` ← wdata[15:0]. No push.
- **Write to `OUTRDATA`:**
  - If not full, or if a pop occurs in the same cycle, push {`holdL`, wdata[15:0]}.
  - Otherwise drop the pair and set `overflow`.
  - `holdL` is unchanged, so repeated right writes reuse the last left sample.
- **Pop (`iSampleReq`=1):**
  - If not empty: pop the head and load `oAudioL`/`oAudioR` with it.
  - If empty: outputs hold their last value and `underrun` is set.
  - There is no bypass: a push in the same cycle as a pop on an empty FIFO is stored, and the pop still underruns.
- **Simultaneous push and pop when not empty and not full:** level is unchanged and both pointers advance.
- **Write to `CTRL`:**
  - bit0=1 flushes the FIFO: pointers and level go to 0. Outputs and `holdL` keep their values.
  - bit1=1 clears both sticky flags.
  - If a push and a flush occur in the same cycle (impossible with a single bus, but specified anyway), flush wins.
- **Read of `STATUS`:** {16'b0, level[7:0], 4'b0, overflow, underrun, full, empty}.
  - The level field is zero-extended. Its width is log2(`DEPTH`)+1.
- **Other read addresses** return 0.
- Writes to unmapped addresses are ignored.
- **Pointers:** wrap modulo `DEPTH`. Level saturates by construction and is never decremented below 0.

## Timing
- **Push latency:** level, `oFull` and `oEmpty` reflect a push on the cycle after the write edge.
- **Pop latency:** `oAudioL`/`oAudioR` update on the `CLK` edge that samples `iSampleReq`, so they are valid the next cycle.
- **Reads:** `oMemReadData` is combinational from registered state and the current address, so the pipeline sees it in the same cycle.
- **Reset:** asserting reset mid-stream clears everything immediately, independent of `CLK`. Deassertion takes effect on the next `CLK` edge.
- **Throughput:** one push and one pop per cycle maximum.

## Structure
- Shared package `audio_mmio_pkg` holds:
  - address constants `OUTRDATA`, `OUTLDATA`, `STATUS`, `CTRL`;
  - status bit indices `ST_EMPTY`=0, `ST_FULL`=1, `ST_UNDERRUN`=2, `ST_OVERFLOW`=3, `ST_LEVEL_LSB`=8;
  - `CTRL` bit indices `CT_FLUSH`=0, `CT_CLRFLAGS`=1.
- One sub-module, `audio_sample_fifo`: a synchronous 32-bit × `DEPTH` FIFO with push, pop, flush, level, full and empty. It contains no MMIO knowledge.
- The top-level block contains the address decode, `holdL`, the output registers, the sticky flags and the read mux.

## Test plan
- **Basic playback:** after reset, write `OUTLDATA`=0x1234, then `OUTRDATA`=0xABCD, then pulse `iSampleReq` → `oAudioL`=0x1234, `oAudioR`=0xABCD, STATUS=0x00000001.
- **Fill and overflow:** 16 pushes give STATUS=0x00001002. A 17th push is dropped and STATUS=0x0000100A. Popping 16 times returns the samples in write order.
- **Underrun:** pulse `iSampleReq` on an empty FIFO → outputs unchanged, underrun bit=1. Writing `CTRL`=0x2 clears it, giving STATUS=0x00000001.
- **Simultaneous push and pop:**
  - At full: the push is accepted and level stays 16.
  - At empty: the new pair is stored, underrun is set and level becomes 1.
- **Flush and reset:**
  - With 5 entries, write `CTRL`=0x1 → level 0 and outputs retained.
  - Asserting `AUD_DACLRCK`=0 mid-stream → all outputs are 0 immediately.
- **Pointer wrap:** 40 interleaved push/pop pairs with sequential data → every popped pair matches, with no gaps or duplicates.

Source files
------------

// File: rtl/audio_mmio_pkg.sv
// Shared MMIO constants for the audio playback path: bus addresses,
// STATUS word bit positions and CTRL command bits.
package audio_mmio_pkg;

    // Bus addresses
    localparam logic [31:0] OUTRDATA = 32'h4000_0008;
    localparam logic [31:0] OUTLDATA = 32'h4000_000C;
    localparam logic [31:0] STATUS   = 32'h4000_0010;
    localparam logic [31:0] CTRL     = 32'h4000_0014;

    // STATUS word layout
    localparam int unsigned ST_EMPTY     = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_UNDERRUN  = 2;
    localparam int unsigned ST_OVERFLOW  = 3;
    localparam int unsigned ST_LEVEL_LSB = 8;

    // CTRL command bits
    localparam int unsigned CT_FLUSH    = 0;
    localparam int unsigned CT_CLRFLAGS = 1;

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous FIFO of packed stereo pairs. Pop is ignored when empty; a push
// at full is accepted only when a pop frees the head slot in the same cycle.
// Flush overrides any push or pop in the same cycle.
module audio_sample_fifo #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [Width-1:0]           wdata_i,
    output logic [Width-1:0]           rdata_o,
    output logic [$clog2(Depth):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned LW = AW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == LW'(Depth));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next-state pointers and occupancy; pointers wrap naturally (Depth is 2^n)
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + LW'(1);
                2'b01:   count_d = count_q - LW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sample storage; contents are only observed while the entry is occupied
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/audio_play_fifo.sv
// MMIO stereo playback buffer: the CPU writes left then right samples, each
// right write pushes the pair, and every frame request pops one pair onto the
// converter outputs. STATUS lets software poll for space and error flags.
module audio_play_fifo #(
    parameter int unsigned DEPTH    = 16,
    parameter logic [31:0] OUTRDATA = audio_mmio_pkg::OUTRDATA,
    parameter logic [31:0] OUTLDATA = audio_mmio_pkg::OUTLDATA,
    parameter logic [31:0] STATUS   = audio_mmio_pkg::STATUS,
    parameter logic [31:0] CTRL     = audio_mmio_pkg::CTRL
) (
    input  logic        CLK,
    input  logic        AUD_DACLRCK,
    input  logic        iMemWrite,
    input  logic        iMemRead,
    input  logic [31:0] iwMemAddress,
    input  logic [31:0] iwMemWriteData,
    output logic [31:0] oMemReadData,
    input  logic        iSampleReq,
    output logic [15:0] oAudioL,
    output logic [15:0] oAudioR,
    output logic        oFull,
    output logic        oEmpty
);

    import audio_mmio_pkg::*;

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [15:0]   hold_l_q, hold_l_d;
    logic [15:0]   out_l_q, out_l_d;
    logic [15:0]   out_r_q, out_r_d;
    logic          underrun_q, underrun_d;
    logic          overflow_q, overflow_d;

    logic          wr_left, wr_right, wr_ctrl;
    logic          flush, clr_flags;
    logic [31:0]   head;
    logic [LW-1:0] level;
    logic          fifo_full, fifo_empty;
    logic [7:0]    level8;
    logic [31:0]   status_word;
    logic          unused_wdata;

    assign wr_left   = iMemWrite && (iwMemAddress == OUTLDATA);
    assign wr_right  = iMemWrite && (iwMemAddress == OUTRDATA);
    assign wr_ctrl   = iMemWrite && (iwMemAddress == CTRL);
    assign flush     = wr_ctrl && iwMemWriteData[CT_FLUSH];
    assign clr_flags = wr_ctrl && iwMemWriteData[CT_CLRFLAGS];
    assign unused_wdata = ^iwMemWriteData[31:16];

    audio_sample_fifo #(
        .Depth (DEPTH),
        .Width (32)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (AUD_DACLRCK),
        .push_i  (wr_right),
        .pop_i   (iSampleReq),
        .flush_i (flush),
        .wdata_i ({hold_l_q, iwMemWriteData[15:0]}),
        .rdata_o (head),
        .level_o (level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next-state for holding register, converter outputs and sticky flags
    always_comb begin
        hold_l_d   = hold_l_q;
        out_l_d    = out_l_q;
        out_r_d    = out_r_q;
        underrun_d = clr_flags ? 1'b0 : underrun_q;
        overflow_d = clr_flags ? 1'b0 : overflow_q;
        if (wr_left) hold_l_d = iwMemWriteData[15:0];
        if (iSampleReq) begin
            if (fifo_empty) begin
                underrun_d = 1'b1;
            end else begin
                out_l_d = head[31:16];
                out_r_d = head[15:0];
            end
        end
        // A pop at full always succeeds, so it makes room for the push
        if (wr_right && fifo_full && !iSampleReq) overflow_d = 1'b1;
    end

    // State registers, cleared asynchronously by the LR clock reset
    always_ff @(posedge CLK or negedge AUD_DACLRCK) begin
        if (!AUD_DACLRCK) begin
            hold_l_q   <= '0;
            out_l_q    <= '0;
            out_r_q    <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            hold_l_q   <= hold_l_d;
            out_l_q    <= out_l_d;
            out_r_q    <= out_r_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    // STATUS assembly and combinational read mux
    always_comb begin
        level8                                = 8'(level);
        status_word                           = '0;
        status_word[ST_EMPTY]                 = fifo_empty;
        status_word[ST_FULL]                  = fifo_full;
        status_word[ST_UNDERRUN]              = underrun_q;
        status_word[ST_OVERFLOW]              = overflow_q;
        status_word[ST_LEVEL_LSB +: 8]        = level8;
        oMemReadData = (iMemRead && (iwMemAddress == STATUS)) ? status_word : '0;
    end

    assign oAudioL = out_l_q;
    assign oAudioR = out_r_q;
    assign oFull   = fifo_full;
    assign oEmpty  = fifo_empty;

endmodule

// File: tb/tb_audio_play_fifo.sv
// Directed bench for audio_play_fifo with hand-computed expectations.
module tb_audio_play_fifo;
    import audio_mmio_pkg::*;

    logic        CLK;
    logic        AUD_DACLRCK;
    logic        iMemWrite;
    logic        iMemRead;
    logic [31:0] iwMemAddress;
    logic [31:0] iwMemWriteData;
    logic [31:0] oMemReadData;
    logic        iSampleReq;
    logic [15:0] oAudioL;
    logic [15:0] oAudioR;
    logic        oFull;
    logic        oEmpty;

    int checks = 0;
    int errors = 0;

    audio_play_fifo dut (
        .CLK            (CLK),
        .AUD_DACLRCK    (AUD_DACLRCK),
        .iMemWrite      (iMemWrite),
        .iMemRead       (iMemRead),
        .iwMemAddress   (iwMemAddress),
        .iwMemWriteData (iwMemWriteData),
        .oMemReadData   (oMemReadData),
        .iSampleReq     (iSampleReq),
        .oAudioL        (oAudioL),
        .oAudioR        (oAudioR),
        .oFull          (oFull),
        .oEmpty         (oEmpty)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK);
        iMemWrite = 1'b1; iwMemAddress = a; iwMemWriteData = d;
        @(negedge CLK);
        iMemWrite = 1'b0; iwMemAddress = '0; iwMemWriteData = '0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] v);
        @(negedge CLK);
        iMemRead = 1'b1; iwMemAddress = a;
        #1 v = oMemReadData;
        iMemRead = 1'b0; iwMemAddress = '0;
    endtask

    task automatic check_status(input string tag, input logic [31:0] exp);
        logic [31:0] v;
        bus_rd(STATUS, v);
        check_eq(tag, v, exp);
    endtask

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        bus_wr(OUTLDATA, {16'h0, l});
        bus_wr(OUTRDATA, {16'h0, r});
    endtask

    task automatic pop_one();
        @(negedge CLK);
        iSampleReq = 1'b1;
        @(negedge CLK);
        iSampleReq = 1'b0;
    endtask

    task automatic push_and_pop(input logic [15:0] r);
        @(negedge CLK);
        iMemWrite = 1'b1; iwMemAddress = OUTRDATA; iwMemWriteData = {16'h0, r};
        iSampleReq = 1'b1;
        @(negedge CLK);
        iMemWrite = 1'b0; iwMemAddress = '0; iwMemWriteData = '0;
        iSampleReq = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [15:0] l, input logic [15:0] r);
        check_eq({tag, "_L"}, {16'h0, oAudioL}, {16'h0, l});
        check_eq({tag, "_R"}, {16'h0, oAudioR}, {16'h0, r});
    endtask

    initial begin
        logic [31:0] v;
        logic [15:0] el, er;

        AUD_DACLRCK = 1'b0; iMemWrite = 1'b0; iMemRead = 1'b0;
        iwMemAddress = '0; iwMemWriteData = '0; iSampleReq = 1'b0;

        // Reset state
        #12;
        check_eq("rst_empty", {31'h0, oEmpty}, 32'h1);
        check_eq("rst_full",  {31'h0, oFull},  32'h0);
        check_out("rst_out", 16'h0, 16'h0);
        check_status("rst_status", 32'h0000_0001);
        @(negedge CLK);
        AUD_DACLRCK = 1'b1;

        // Basic playback
        push_pair(16'h1234, 16'hABCD);
        check_status("basic_lvl1", 32'h0000_0100);
        pop_one();
        check_out("basic_pop", 16'h1234, 16'hABCD);
        check_status("basic_empty", 32'h0000_0001);

        // Fill and overflow
        for (int i = 0; i < 16; i++) begin
            el = 16'h1000 + 16'(i);
            er = 16'h2000 + 16'(i);
            push_pair(el, er);
        end
        check_status("fill_16", 32'h0000_1002);
        check_eq("fill_ofull", {31'h0, oFull}, 32'h1);
        bus_wr(OUTRDATA, 32'h0000_2FFF);
        check_status("overflow", 32'h0000_100A);
        for (int i = 0; i < 16; i++) begin
            pop_one();
            el = 16'h1000 + 16'(i);
            er = 16'h2000 + 16'(i);
            check_out("fill_pop", el, er);
        end
        check_status("drained_ovf", 32'h0000_0009);

        // Underrun and flag clear
        pop_one();
        check_out("underrun_hold", 16'h100F, 16'h200F);
        check_status("underrun", 32'h0000_000D);
        bus_wr(CTRL, 32'h2);
        check_status("clrflags", 32'h0000_0001);

        // Simultaneous push and pop at full
        for (int i = 0; i < 16; i++) begin
            el = 16'h3000 + 16'(i);
            er = 16'h4000 + 16'(i);
            push_pair(el, er);
        end
        push_and_pop(16'h5555);
        check_out("pp_full_pop", 16'h3000, 16'h4000);
        check_status("pp_full_lvl", 32'h0000_1002);
        for (int i = 1; i < 16; i++) begin
            pop_one();
            el = 16'h3000 + 16'(i);
            er = 16'h4000 + 16'(i);
            check_out("pp_full_drain", el, er);
        end
        pop_one();
        check_out("pp_full_last", 16'h300F, 16'h5555);
        check_status("pp_full_empty", 32'h0000_0001);

        // Simultaneous push and pop at empty: stored, still underruns
        bus_wr(OUTLDATA, 32'h0000_6666);
        push_and_pop(16'h7777);
        check_out("pp_empty_hold", 16'h300F, 16'h5555);
        check_status("pp_empty_st", 32'h0000_0104);
        pop_one();
        check_out("pp_empty_pop", 16'h6666, 16'h7777);
        bus_wr(CTRL, 32'h2);
        check_status("pp_empty_clr", 32'h0000_0001);

        // Flush with five entries
        for (int i = 0; i < 5; i++) begin
            el = 16'h8000 + 16'(i);
            er = 16'h9000 + 16'(i);
            push_pair(el, er);
        end
        check_status("flush_pre", 32'h0000_0500);
        bus_wr(CTRL, 32'h1);
        check_status("flush_post", 32'h0000_0001);
        check_out("flush_out", 16'h6666, 16'h7777);
        check_eq("flush_empty", {31'h0, oEmpty}, 32'h1);

        // Unmapped writes and reads
        bus_wr(32'h4000_0000, 32'h0000_FFFF);
        bus_wr(32'h4000_0004, 32'h0000_0003);
        check_status("unmapped_wr", 32'h0000_0001);
        bus_rd(OUTLDATA, v);
        check_eq("rd_other", v, 32'h0);
        @(negedge CLK);
        iwMemAddress = STATUS;
        #1 check_eq("rd_nostrobe", oMemReadData, 32'h0);
        iwMemAddress = '0;

        // Pointer wrap: interleaved push/pop with sequential data
        for (int i = 0; i < 40; i++) begin
            el = 16'hA000 + 16'(i);
            er = 16'hB000 + 16'(i);
            push_pair(el, er);
            pop_one();
            check_out("wrap", el, er);
        end
        check_status("wrap_end", 32'h0000_0001);

        // Asynchronous reset mid-stream
        push_pair(16'h1111, 16'h2222);
        push_pair(16'h3333, 16'h4444);
        pop_one();
        check_out("mid_pre", 16'h1111, 16'h2222);
        @(negedge CLK);
        #2 AUD_DACLRCK = 1'b0;
        #1;
        check_out("mid_rst", 16'h0, 16'h0);
        check_eq("mid_rst_empty", {31'h0, oEmpty}, 32'h1);
        check_status("mid_rst_st", 32'h0000_0001);
        @(negedge CLK);
        AUD_DACLRCK = 1'b1;
        bus_wr(OUTRDATA, 32'h0000_5555);
        pop_one();
        check_out("holdl_cleared", 16'h0000, 16'h5555);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
